// File: rtl/instr_fetch_unit_pkg.sv
// instr_fetch_unit_pkg: shared fetch-stage state encodings and the NOP constant
package instr_fetch_unit_pkg;
  typedef enum logic [1:0] {
    FETCH_IDLE  = 2'd0,
    FETCH_WAIT  = 2'd1,
    FETCH_DRAIN = 2'd2
  } fetch_state_e;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
endpackage

// File: rtl/instr_fetch_unit_if.sv
// instr_fetch_unit_if: instruction-memory read handshake between fetch unit and memory
interface instr_fetch_unit_if;
  logic        mem_valid;
  logic [31:0] mem_addr;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  modport master(output mem_valid, mem_addr, input mem_ready, mem_rdata);
  modport slave(input mem_valid, mem_addr, output mem_ready, mem_rdata);
endinterface

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: multicycle fetch FSM + instruction register; FETCH_MISALIGN_TRAP_EN adds fetch_misaligned trap
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_INSTR = NOP_INSTR,
  parameter logic [31:0] RESET_PC    = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               fetch_req,
  input  logic [31:0]        pc,
  input  logic               flush,
  instr_fetch_unit_if.master mem,
  output logic [31:0]        instr,
  output logic [31:0]        oldpc,
  output logic               instr_valid,
  output logic               busy
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic               fetch_misaligned
`endif
);
  fetch_state_e state_q, state_d;
  logic [31:0] pc_q;
  logic start, done, load, drop;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic misaligned;
`endif
  // next-state and per-cycle decisions; a flushed transaction still completes on the bus
  always_comb begin
`ifdef FETCH_MISALIGN_TRAP_EN
    misaligned = state_q == FETCH_IDLE && fetch_req && pc[1:0] != 2'b00;
    start      = state_q == FETCH_IDLE && fetch_req && !misaligned;
`else
    start      = state_q == FETCH_IDLE && fetch_req;
`endif
    done    = state_q != FETCH_IDLE && mem.mem_ready;
    load    = state_q == FETCH_WAIT && mem.mem_ready && !flush;
    drop    = (state_q == FETCH_IDLE && flush) || (done && !load);
    state_d = start ? FETCH_WAIT :
              done ? FETCH_IDLE :
              (state_q == FETCH_WAIT && flush) ? FETCH_DRAIN : state_q;
  end
  // state register
  always_ff @(posedge clk) begin
    if (reset) state_q <= FETCH_IDLE;
    else state_q <= state_d;
  end
  // request, instruction register and status outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      mem.mem_valid <= 1'b0;
      mem.mem_addr  <= '0;
      pc_q          <= RESET_PC;
      instr         <= RESET_INSTR;
      oldpc         <= RESET_PC;
      instr_valid   <= 1'b0;
      busy          <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
      fetch_misaligned <= 1'b0;
`endif
    end else begin
      mem.mem_valid <= state_d != FETCH_IDLE;
      busy          <= state_d != FETCH_IDLE;
      mem.mem_addr  <= start ? {pc[31:2], 2'b00} : mem.mem_addr;
      pc_q          <= start ? pc : pc_q;
      instr         <= load ? mem.mem_rdata : drop ? RESET_INSTR : instr;
      instr_valid   <= load;
`ifdef FETCH_MISALIGN_TRAP_EN
      oldpc            <= load ? pc_q : misaligned ? pc : oldpc;
      fetch_misaligned <= misaligned;
`else
      oldpc         <= load ? pc_q : oldpc;
`endif
    end
  end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed + randomized check of instr_fetch_unit against a transaction-level model
module tb_instr_fetch_unit;
  logic clk = 0, reset = 1, fetch_req = 0, flush = 0, mem_ready = 0;
  logic [31:0] pc = 0, mem_rdata = 0;
  logic [31:0] instr, oldpc;
  logic instr_valid, busy;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic fetch_misaligned;
`endif
  int checks = 0, errors = 0;
  bit armed = 0;
  bit m_busy, m_drop, m_iv, m_mis;
  logic [31:0] m_addr, m_pc, m_ir, m_oldpc, imm;

  instr_fetch_unit_if mif();
  assign mif.mem_ready = mem_ready;
  assign mif.mem_rdata = mem_rdata;

  instr_fetch_unit dut (
    .clk(clk), .reset(reset), .fetch_req(fetch_req), .pc(pc), .flush(flush), .mem(mif),
    .instr(instr), .oldpc(oldpc), .instr_valid(instr_valid), .busy(busy)
`ifdef FETCH_MISALIGN_TRAP_EN
    , .fetch_misaligned(fetch_misaligned)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  // model: one outstanding request, optionally marked as discarded by a flush
  always @(posedge clk) begin
    bit nv, nm;
    nv = 0;
    nm = 0;
    if (reset) begin
      m_busy = 0; m_drop = 0; m_addr = 0; m_pc = 0; m_ir = 32'h13; m_oldpc = 0;
    end else if (!m_busy) begin
      if (flush) m_ir = 32'h13;
      if (fetch_req) begin
`ifdef FETCH_MISALIGN_TRAP_EN
        if (pc[1:0] != 2'b00) begin nm = 1; m_oldpc = pc; end else
`endif
        begin m_busy = 1; m_addr = pc & 32'hFFFF_FFFC; m_pc = pc; end
      end
    end else if (mem_ready) begin
      if (m_drop || flush) m_ir = 32'h13;
      else begin m_ir = mem_rdata; m_oldpc = m_pc; nv = 1; end
      m_busy = 0;
      m_drop = 0;
    end else if (flush) m_drop = 1;
    m_iv = nv;
    m_mis = nm;
    armed = 1;
  end

  // every-cycle comparison against the model, away from the active edge
  always @(negedge clk) if (armed) begin
    chk("mem_valid", mif.mem_valid, m_busy);
    chk("busy", busy, m_busy);
    chk("mem_addr", mif.mem_addr, m_addr);
    chk("instr", instr, m_ir);
    chk("oldpc", oldpc, m_oldpc);
    chk("instr_valid", instr_valid, m_iv);
`ifdef FETCH_MISALIGN_TRAP_EN
    chk("fetch_misaligned", fetch_misaligned, m_mis);
`endif
  end

  initial begin
    cyc(); cyc();
    chk("rst_instr", instr, 32'h13);
    chk("rst_oldpc", oldpc, 32'h0);
    chk("rst_mem_valid", mif.mem_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_addr", mif.mem_addr, 32'h0);
    reset = 0; fetch_req = 1; pc = 32'h100; cyc();
    fetch_req = 0;
    chk("zw_busy", busy, 1); chk("zw_valid", mif.mem_valid, 1); chk("zw_addr", mif.mem_addr, 32'h100);
    mem_ready = 1; mem_rdata = 32'hFFF00093; cyc();
    mem_ready = 0;
    chk("zw_iv", instr_valid, 1); chk("zw_instr", instr, 32'hFFF00093);
    chk("zw_oldpc", oldpc, 32'h100); chk("zw_valid_drop", mif.mem_valid, 0);
    imm = {7'b0, instr[31:7]};
    repeat (3) begin
      cyc();
      chk("imm_stable", {7'b0, instr[31:7]}, imm);
      chk("zw_iv_once", instr_valid, 0);
    end
    fetch_req = 1; pc = 32'h200; cyc();
    fetch_req = 0;
    repeat (5) begin
      chk("ws_valid", mif.mem_valid, 1); chk("ws_addr", mif.mem_addr, 32'h200);
      chk("ws_busy", busy, 1); chk("ws_iv", instr_valid, 0);
      cyc();
    end
    mem_ready = 1; mem_rdata = 32'h12345678; cyc();
    mem_ready = 0;
    chk("ws_iv_pulse", instr_valid, 1); chk("ws_instr", instr, 32'h12345678); chk("ws_oldpc", oldpc, 32'h200);
    cyc();
    chk("ws_iv_single", instr_valid, 0);
    fetch_req = 1; pc = 32'h300; cyc();
    fetch_req = 0; cyc();
    flush = 1; cyc();
    flush = 0;
    chk("fl_drain_valid", mif.mem_valid, 1); chk("fl_drain_addr", mif.mem_addr, 32'h300);
    chk("fl_drain_instr", instr, 32'h12345678);
    cyc();
    mem_ready = 1; mem_rdata = 32'hDEADBEEF; cyc();
    mem_ready = 0;
    chk("fl_iv", instr_valid, 0); chk("fl_instr", instr, 32'h13);
    chk("fl_busy", busy, 0); chk("fl_valid", mif.mem_valid, 0); chk("fl_oldpc", oldpc, 32'h200);
    fetch_req = 1; pc = 32'h400; cyc();
    fetch_req = 0; mem_ready = 1; mem_rdata = 32'h00A00513; cyc();
    mem_ready = 0;
    chk("co_pre_instr", instr, 32'h00A00513);
    fetch_req = 1; pc = 32'h404; cyc();
    fetch_req = 0; flush = 1; mem_ready = 1; mem_rdata = 32'hCAFEF00D; cyc();
    flush = 0; mem_ready = 0;
    chk("co_instr", instr, 32'h13); chk("co_iv", instr_valid, 0);
    chk("co_oldpc", oldpc, 32'h400); chk("co_busy", busy, 0);
    fetch_req = 1; pc = 32'h500; cyc();
    fetch_req = 0; mem_ready = 1; mem_rdata = 32'h11111111; cyc();
    mem_ready = 0;
    chk("b2b_iv", instr_valid, 1);
    fetch_req = 1; pc = 32'h504; cyc();
    fetch_req = 0;
    chk("b2b_valid", mif.mem_valid, 1); chk("b2b_addr", mif.mem_addr, 32'h504); chk("b2b_hold", instr, 32'h11111111);
    mem_ready = 1; mem_rdata = 32'h22222222; cyc();
    mem_ready = 0;
    chk("b2b_instr", instr, 32'h22222222); chk("b2b_oldpc", oldpc, 32'h504);
    fetch_req = 1; pc = 32'h102; cyc();
    fetch_req = 0;
`ifdef FETCH_MISALIGN_TRAP_EN
    chk("mis_pulse", fetch_misaligned, 1); chk("mis_valid", mif.mem_valid, 0);
    chk("mis_oldpc", oldpc, 32'h102); chk("mis_instr", instr, 32'h22222222); chk("mis_iv", instr_valid, 0);
    cyc();
    chk("mis_pulse_end", fetch_misaligned, 0);
`else
    chk("al_valid", mif.mem_valid, 1); chk("al_addr", mif.mem_addr, 32'h100);
    mem_ready = 1; mem_rdata = 32'h33333333; cyc();
    mem_ready = 0;
    chk("al_instr", instr, 32'h33333333);
`endif
    fetch_req = 1; pc = 32'h600; cyc();
    fetch_req = 0; reset = 1; cyc();
    reset = 0;
    chk("mr_valid", mif.mem_valid, 0); chk("mr_busy", busy, 0);
    chk("mr_instr", instr, 32'h13); chk("mr_oldpc", oldpc, 32'h0);
    repeat (3000) begin
      reset = $urandom_range(0, 199) == 0;
      fetch_req = $urandom_range(0, 2) == 0;
      pc = $urandom;
      flush = $urandom_range(0, 9) == 0;
      mem_ready = m_busy && $urandom_range(0, 2) == 0;
      mem_rdata = $urandom;
      cyc();
    end
    reset = 0; fetch_req = 0; flush = 0; mem_ready = 0;
    cyc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
